// File: rtl/hsc_uart_pkg.sv
// Shared types and helpers for the HSC UART receive path.
package hsc_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/hsc_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs.
module hsc_sync2 #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hsc_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a single-entry valid/ready holding register.
//
//   state | meaning
//   IDLE  | line idle, waiting for a 1->0 edge on rx_s
//   START | half a bit in, confirm the start bit is still low
//   DATA  | sample 8 data bits at bit centres, LSB first
//   STOP  | sample the stop bit, deliver or flag a framing error
//   BREAK | line held low after a bad stop bit, wait for it to go high
module hsc_uart_rx
  import hsc_uart_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 ovr_clr_i,
  output logic                 busy_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 rx_q;

  // Preset high so reset release on an idle line never looks like a start edge.
  hsc_sync2 #(.INIT(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_q        <= 1'b1;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      rx_q        <= rx_s;
      frame_err_o <= 1'b0;
      cnt         <= cnt + 1'b1;

      // Consumption and overrun clear come first so a same-cycle delivery or overrun overrides them.
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (ovr_clr_i) overrun_o <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_q && !rx_s) begin
            state  <= START;
            busy_o <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end

        DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) state <= STOP;
          end
        end

        STOP: begin
          if (cnt == CNT_BIT_END) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        end

        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsc_uart_rx.sv
// Directed bench for hsc_uart_rx at 12 MHz / 115200 baud (104 clocks per bit).
module tb_hsc_uart_rx;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ready_i = 1'b0;
  logic       ovr_clr_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_run = 0;
  int n_fail = 0;

  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] last_data = 8'h00;

  int v0, f0, b0;

  always #5 clk = ~clk;

  hsc_uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .ovr_clr_i   (ovr_clr_i),
    .busy_o      (busy_o)
  );

  always @(negedge clk) begin
    if (valid_o) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= data_o;
    end
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (busy_o) busy_cnt <= busy_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_bit;
    cycles(CPB);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    cycles(3);
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    reset = 1'b0;
    cycles(5);
    chk("post_rst_busy", 32'(busy_o), 32'h0);

    // 1: clean 0xA5 with ready high
    ready_i = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    cycles(20);
    chk("t1_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    chk("t1_data_seen", 32'(last_data), 32'hA5);
    chk("t1_data_held", 32'(data_o), 32'hA5);
    chk("t1_valid_low", 32'(valid_o), 32'h0);
    chk("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t1_ovr", 32'(overrun_o), 32'h0);

    // 2: 30-cycle glitch rejected at half-bit check
    v0 = valid_cnt;
    f0 = ferr_cnt;
    b0 = busy_cnt;
    rx = 1'b0;
    cycles(30);
    rx = 1'b1;
    cycles(100);
    chk("t2_busy_cycles", 32'(busy_cnt - b0), 32'd52);
    chk("t2_busy_end", 32'(busy_o), 32'h0);
    chk("t2_valid", 32'(valid_cnt - v0), 32'd0);
    chk("t2_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 3: bad stop bit then held-low line
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    cycles(500);
    chk("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    chk("t3_busy_break", 32'(busy_o), 32'h1);
    chk("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
    rx = 1'b1;
    cycles(10);
    chk("t3_idle_after", 32'(busy_o), 32'h0);
    cycles(300);
    chk("t3_no_second", 32'(valid_cnt - v0), 32'd0);
    chk("t3_ferr_total", 32'(ferr_cnt - f0), 32'd1);
    chk("t3_busy_quiet", 32'(busy_o), 32'h0);

    // 4: overrun with consumer stalled
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    chk("t4_first_valid", 32'(valid_o), 32'h1);
    chk("t4_first_ovr", 32'(overrun_o), 32'h0);
    send_frame(8'h22, 1'b1);
    chk("t4_data_kept", 32'(data_o), 32'h11);
    chk("t4_valid", 32'(valid_o), 32'h1);
    chk("t4_ovr_set", 32'(overrun_o), 32'h1);
    ovr_clr_i = 1'b1;
    cycles(1);
    ovr_clr_i = 1'b0;
    chk("t4_ovr_clr", 32'(overrun_o), 32'h0);
    chk("t4_data_after_clr", 32'(data_o), 32'h11);
    chk("t4_valid_after_clr", 32'(valid_o), 32'h1);

    // 5: consume 0x11 in the very cycle 0x55 is delivered
    fork
      send_frame(8'h55, 1'b1);
      begin
        cycles(990);
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
      end
    join
    chk("t5_data", 32'(data_o), 32'h55);
    chk("t5_valid", 32'(valid_o), 32'h1);
    chk("t5_ovr", 32'(overrun_o), 32'h0);

    // 6: reset in the middle of bit 4 of 0xFF
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      cycles(CPB);
    end
    rx = 1'b1;
    cycles(52);
    chk("t6_busy_pre", 32'(busy_o), 32'h1);
    chk("t6_valid_pre", 32'(valid_o), 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_data", 32'(data_o), 32'h00);
    chk("t6_rst_valid", 32'(valid_o), 32'h0);
    chk("t6_rst_busy", 32'(busy_o), 32'h0);
    chk("t6_rst_ferr", 32'(frame_err_o), 32'h0);
    chk("t6_rst_ovr", 32'(overrun_o), 32'h0);
    cycles(3);
    reset = 1'b0;
    cycles(20);
    chk("t6_idle_after_rst", 32'(busy_o), 32'h0);
    ready_i = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1);
    cycles(20);
    chk("t6_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    chk("t6_data_seen", 32'(last_data), 32'h81);
    chk("t6_ferr", 32'(ferr_cnt - f0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
